inputc: RTL and testbench
=========================

Name: inputc

Overview:
- Receive end of the router link protocol. The upstream output channel sends one flit per cycle, tagged with a virtual channel (VC).
- Buffers flits in per-VC FIFOs and presents the head of each FIFO to the crossbar/arbiter.
- Returns one credit (ack) pulse per dequeued flit.
- Holds a per-VC lock indication while any packet on that VC remains in the buffer. The upstream side releases its VC reservation when this lock drops.

Parameters:
- ROUTERID, 0, router index (debug/assertion tags only)
- PCHID, 0, physical-channel index (debug/assertion tags only)
- DATA_W, 34, flit width. Bits [DATA_W-1:DATA_W-2] are the flit type.
- VCH_N, 2, number of virtual channels
- FIFO_D, 4, per-VC FIFO depth in flits. Must be a power of 2 and ≥2.

Ports:
- clk, input, 1, clock
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, flit present this cycle
- in_vch, input, clog2(VCH_N), VC of incoming flit
- in_data, input, DATA_W, incoming flit
- pop_i, input, VCH_N, per-VC dequeue request from switch allocator
- out_valid, output, VCH_N, per-VC FIFO non-empty
- out_data, output, VCH_N*DATA_W, per-VC head flit (show-ahead)
- ack_o, output, VCH_N, per-VC credit return to upstream
- lck_o, output, VCH_N, per-VC packet-in-buffer lock to upstream
- err_o, output, 1, sticky protocol/overflow error

Behaviour:
- Reset is asynchronous on rst_n low, with clock clk.
  - On reset, all FIFOs are emptied and all pointers/counters clear.
  - out_valid=0, out_data=0, ack_o=0, lck_o=0, err_o=0.
  - Reset mid-packet discards all buffered flits; no acks are issued for them.
- Flit type encoding: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL.
- Push:
  - When in_valid=1, in_data is written to FIFO[in_vch] at the rising edge.
  - The flit is visible on out_valid/out_data the next cycle (1-cycle latency).
- Pop:
  - pop_i[i]=1 with out_valid[i]=1 advances FIFO i; the next flit appears the following cycle.
  - pop_i[i] while empty is ignored and produces no ack.
- Occupancy:
  - Per-VC count width is clog2(FIFO_D)+1.
  - count_d = count_q + push - pop, with push and pop evaluated independently.
  - Push and pop on the same VC in the same cycle is legal at full and at empty. The count is unchanged; at empty, the flit lands and becomes visible next cycle.
- Overflow:
  - A push to a full VC with no same-cycle pop is dropped, and err_o is set.
  - The FIFO contents and count are unchanged.
- Pointers wrap modulo FIFO_D.
- Credit:
  - ack_o[i] is registered: it pulses high exactly one cycle after each accepted pop on VC i.
  - Back-to-back pops give back-to-back ack pulses.
  - Sum of ack pulses on VC i equals flits popped from VC i.
- Per-VC packet counter pkt_q[i]:
  - Width clog2(FIFO_D)+1.
  - Increments on push of HEAD or HEADTAIL.
  - Decrements on pop of TAIL or HEADTAIL.
  - Both events in the same cycle leave it unchanged.
  - lck_o[i] = (pkt_q[i] != 0), registered.
- Per-VC receive FSM, which tracks the incoming packet framing:
  - IDLE → IN_PKT on HEAD push.
  - IN_PKT → IDLE on TAIL push.
  - HEADTAIL leaves the state in IDLE.
  - Protocol errors: BODY or TAIL pushed in IDLE, or HEAD or HEADTAIL pushed in IN_PKT. On error, err_o is set, the flit is still stored, and the state follows the normal transition for that type.
- err_o stays high until reset.
- out_data[i] when out_valid[i]=0 is don't-care; the implementation drives 0.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release → all outputs 0; out_valid=00, ack_o=00, lck_o=00 for 5 idle cycles.
- Single packet: VC0 push HEAD(type01), BODY, TAIL on 3 consecutive cycles, then pop 3 cycles →
  - out_valid[0] rises 1 cycle after the first push.
  - lck_o[0]=1 from cycle after HEAD until cycle after TAIL popped.
  - ack_o[0] pulses 3 times, each 1 cycle after its pop.
  - err_o=0.
- Fill/overflow: VC1 push 5 BODY-framed flits (HEAD, 3 BODY, TAIL) with no pops →
  - First 4 stored, count=4.
  - 5th dropped; err_o=1 the next cycle.
  - Popping 4 gives exactly 4 ack pulses.
- Full with simultaneous push/pop: VC0 full (4 flits), push+pop the same cycle → count stays 4, err_o=0, new flit emerges after 4 further pops; wrap-around verified over 10 packets.
- Interleaved VCs: alternate HEADTAIL flits on VC0/VC1, pop VC1 only → lck_o=11; VC0 acks absent; VC1 acks match pops; lck_o[1] drops once its last HEADTAIL is popped.
- Protocol error and reset mid-packet:
  - BODY to IDLE VC0 → err_o=1.
  - Then rst_n=0 with VC1 holding 2 flits → all outputs 0 next cycle, no acks after release.

Source files
------------

// File: rtl/inputc.sv
// inputc: receive end of the router link.
// Incoming flits go into a FIFO per virtual channel. The head of each FIFO is
// shown to the crossbar as soon as it is written, with no extra cycle of delay.
// Each accepted pop returns one credit on ack_o in the next cycle.
// lck_o[i] stays high while any packet on VC i is still in the buffer.
//
// Receive framing FSM, one copy per VC:
//   state    | meaning
//   S_IDLE   | between packets; expects HEAD or HEADTAIL
//   S_IN_PKT | HEAD received; expects BODY or TAIL
module inputc #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int DATA_W   = 34,
    parameter int VCH_N    = 2,
    parameter int FIFO_D   = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    input  logic [((VCH_N > 1) ? $clog2(VCH_N) : 1)-1:0]  in_vch,
    input  logic [DATA_W-1:0]                             in_data,
    input  logic [VCH_N-1:0]                              pop_i,
    output logic [VCH_N-1:0]                              out_valid,
    output logic [VCH_N*DATA_W-1:0]                       out_data,
    output logic [VCH_N-1:0]                              ack_o,
    output logic [VCH_N-1:0]                              lck_o,
    output logic                                          err_o
);

    localparam int VW = (VCH_N > 1) ? $clog2(VCH_N) : 1;
    localparam int PW = $clog2(FIFO_D);
    localparam int CW = PW + 1;

    localparam logic [1:0] T_BODY     = 2'b00;
    localparam logic [1:0] T_HEAD     = 2'b01;
    localparam logic [1:0] T_TAIL     = 2'b10;
    localparam logic [1:0] T_HEADTAIL = 2'b11;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } rx_state_t;

    logic [DATA_W-1:0] mem_q    [VCH_N][FIFO_D];
    logic [DATA_W-1:0] mem_d    [VCH_N][FIFO_D];
    logic [PW-1:0]     wr_ptr_q [VCH_N];
    logic [PW-1:0]     wr_ptr_d [VCH_N];
    logic [PW-1:0]     rd_ptr_q [VCH_N];
    logic [PW-1:0]     rd_ptr_d [VCH_N];
    logic [CW-1:0]     cnt_q    [VCH_N];
    logic [CW-1:0]     cnt_d    [VCH_N];
    logic [CW-1:0]     pkt_q    [VCH_N];
    logic [CW-1:0]     pkt_d    [VCH_N];
    rx_state_t         rx_state_q [VCH_N];
    rx_state_t         rx_state_d [VCH_N];

    logic [VCH_N-1:0]  ack_q, ack_d;
    logic [VCH_N-1:0]  lck_q, lck_d;
    logic              err_q, err_d;

    logic [VCH_N-1:0]  sel;
    logic [VCH_N-1:0]  push_ok;
    logic [VCH_N-1:0]  pop_ok;
    logic [VCH_N-1:0]  ovf;
    logic [VCH_N-1:0]  pkt_inc;
    logic [VCH_N-1:0]  pkt_dec;
    logic [VCH_N-1:0]  proto_err;
    logic [1:0]        in_type;
    logic [1:0]        head_type [VCH_N];

    assign in_type = in_data[DATA_W-1 -: 2];

    // Per-VC accept decisions. A pop is accepted only on a non-empty FIFO.
    // A push to a full FIFO is accepted only when the same VC pops in that cycle.
    always_comb begin
        sel     = '0;
        push_ok = '0;
        pop_ok  = '0;
        ovf     = '0;
        pkt_inc = '0;
        pkt_dec = '0;
        for (int i = 0; i < VCH_N; i++) begin
            head_type[i] = mem_q[i][rd_ptr_q[i]][DATA_W-1 -: 2];
            sel[i]       = in_valid && (in_vch == VW'(i));
            pop_ok[i]    = pop_i[i] && (cnt_q[i] != '0);
            push_ok[i]   = sel[i] && ((cnt_q[i] != CW'(FIFO_D)) || pop_ok[i]);
            ovf[i]       = sel[i] && !push_ok[i];
            pkt_inc[i]   = push_ok[i] && ((in_type == T_HEAD) || (in_type == T_HEADTAIL));
            pkt_dec[i]   = pop_ok[i] && ((head_type[i] == T_TAIL) || (head_type[i] == T_HEADTAIL));
        end
    end

    // FIFO storage, pointer, occupancy and packet-count next values.
    // The pointers are PW bits wide, so they wrap modulo FIFO_D without extra logic.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < VCH_N; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (push_ok[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data;
                wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
            end
            if (pop_ok[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            end
            cnt_d[i] = cnt_q[i] + CW'(push_ok[i]) - CW'(pop_ok[i]);
            pkt_d[i] = pkt_q[i] + CW'(pkt_inc[i]) - CW'(pkt_dec[i]);
            lck_d[i] = (pkt_d[i] != '0);
        end
        ack_d = pop_ok;
        err_d = err_q | (|ovf) | (|proto_err);
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VCH_N; i++) begin
                for (int j = 0; j < FIFO_D; j++) begin
                    mem_q[i][j] <= '0;
                end
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                pkt_q[i]    <= '0;
            end
            ack_q <= '0;
            lck_q <= '0;
            err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            pkt_q    <= pkt_d;
            ack_q    <= ack_d;
            lck_q    <= lck_d;
            err_q    <= err_d;
        end
    end

    // Framing FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VCH_N; i++) begin
                rx_state_q[i] <= S_IDLE;
            end
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    // Framing FSM next state.
    // Only stored flits advance the FSM. A flit that breaks the framing still
    // takes the normal transition for its type.
    always_comb begin
        for (int i = 0; i < VCH_N; i++) begin
            rx_state_d[i] = rx_state_q[i];
            if (push_ok[i]) begin
                case (in_type)
                    T_HEAD:     rx_state_d[i] = S_IN_PKT;
                    T_TAIL:     rx_state_d[i] = S_IDLE;
                    T_HEADTAIL: rx_state_d[i] = S_IDLE;
                    default:    rx_state_d[i] = rx_state_q[i];
                endcase
            end
        end
    end

    // Framing FSM output: flag a flit type that is illegal in the current state.
    always_comb begin
        proto_err = '0;
        for (int i = 0; i < VCH_N; i++) begin
            if (push_ok[i]) begin
                if (rx_state_q[i] == S_IDLE) begin
                    proto_err[i] = (in_type == T_BODY) || (in_type == T_TAIL);
                end else begin
                    proto_err[i] = (in_type == T_HEAD) || (in_type == T_HEADTAIL);
                end
            end
        end
    end

    // Head-of-FIFO presentation. An empty VC drives zero data.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < VCH_N; i++) begin
            out_valid[i] = (cnt_q[i] != '0);
            if (out_valid[i]) begin
                out_data[i*DATA_W +: DATA_W] = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    assign ack_o = ack_q;
    assign lck_o = lck_q;
    assign err_o = err_q;

    // Occupancy must never go past the FIFO depth.
    always @(posedge clk) begin
        for (int i = 0; i < VCH_N; i++) begin
            if (rst_n) begin
                assert (cnt_q[i] <= CW'(FIFO_D))
                else $error("inputc r%0d p%0d vc%0d: occupancy overrun", ROUTERID, PCHID, i);
            end
        end
    end

endmodule

// File: tb/tb_inputc.sv
// Bench for inputc: directed stimulus. A queue-based reference model is checked
// on every cycle, and literal spot checks pin that model.
module tb_inputc;

    localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HT = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [0:0]  in_vch = '0;
    logic [33:0] in_data = '0;
    logic [1:0]  pop = '0;
    logic [1:0]  out_valid;
    logic [67:0] out_data;
    logic [1:0]  ack_o;
    logic [1:0]  lck_o;
    logic        err_o;

    int nvec = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    inputc #(.ROUTERID(0), .PCHID(0), .DATA_W(34), .VCH_N(2), .FIFO_D(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_vch   (in_vch),
        .in_data  (in_data),
        .pop_i    (pop),
        .out_valid(out_valid),
        .out_data (out_data),
        .ack_o    (ack_o),
        .lck_o    (lck_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] mk(input logic [1:0] t, input int p);
        logic [31:0] pl;
        pl = p;
        return {t, pl};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue of flits per VC, plus packet counts and framing.
    logic [33:0] mq [2][$];
    int          pk [2];
    bit          inpk [2];
    bit          merr;
    logic [1:0]  mack;

    always @(posedge clk or negedge rst_n) begin
        logic        pa, pu, here;
        logic [33:0] f;
        logic [1:0]  t;
        if (!rst_n) begin
            for (int v = 0; v < 2; v++) begin
                mq[v].delete();
                pk[v]   = 0;
                inpk[v] = 1'b0;
            end
            merr = 1'b0;
            mack = 2'b00;
        end else begin
            for (int v = 0; v < 2; v++) begin
                here = in_valid && (int'(in_vch) == v);
                pa   = pop[v] && (mq[v].size() > 0);
                pu   = here && ((mq[v].size() < 4) || pa);
                mack[v] = pa;
                if (pa) begin
                    f = mq[v].pop_front();
                    if (f[33:32] == TAIL || f[33:32] == HT) pk[v]--;
                end
                if (here && !pu) merr = 1'b1;
                if (pu) begin
                    t = in_data[33:32];
                    mq[v].push_back(in_data);
                    if (t == HEAD || t == HT) pk[v]++;
                    if (!inpk[v] && (t == BODY || t == TAIL)) merr = 1'b1;
                    if (inpk[v] && (t == HEAD || t == HT)) merr = 1'b1;
                    if (t == HEAD) inpk[v] = 1'b1;
                    else if (t != BODY) inpk[v] = 1'b0;
                end
            end
        end
    end

    // Compare the outputs with the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        logic [1:0]  ev, el;
        logic [67:0] ed;
        if (chk_on) begin
            ev = '0; el = '0; ed = '0;
            for (int v = 0; v < 2; v++) begin
                ev[v] = (mq[v].size() > 0);
                el[v] = (pk[v] != 0);
                if (ev[v]) ed[v*34 +: 34] = mq[v][0];
            end
            chk("model out_valid", 128'(out_valid), 128'(ev));
            chk("model out_data", 128'(out_data), 128'(ed));
            chk("model ack_o", 128'(ack_o), 128'(mack));
            chk("model lck_o", 128'(lck_o), 128'(el));
            chk("model err_o", 128'(err_o), 128'(merr));
        end
    end

    task automatic step(input logic v, input int vc, input logic [33:0] d, input logic [1:0] p);
        in_valid = v;
        in_vch   = 1'(vc);
        in_data  = d;
        pop      = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, '0, 2'b00);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        pop      = 2'b00;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        rst_n  = 1'b1;
    endtask

    int acks;

    initial begin
        // Reset and idle
        do_reset();
        chk("reset out_valid", 128'(out_valid), 128'(2'b00));
        chk("reset out_data", 128'(out_data), 128'(0));
        chk("reset ack/lck/err", 128'({ack_o, lck_o, err_o}), 128'(5'b0));
        idle(5);
        chk("idle status", 128'({out_valid, ack_o, lck_o}), 128'(6'b0));

        // Single packet on VC0
        step(1'b1, 0, mk(HEAD, 32'h100), 2'b00);
        chk("pkt out_valid rise", 128'(out_valid), 128'(2'b01));
        chk("pkt lck rise", 128'(lck_o), 128'(2'b01));
        chk("pkt head data", 128'(out_data[33:0]), 128'(mk(HEAD, 32'h100)));
        step(1'b1, 0, mk(BODY, 32'h101), 2'b00);
        step(1'b1, 0, mk(TAIL, 32'h102), 2'b00);
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 0, '0, 2'b01);
            acks += int'(ack_o[0]);
            if (k < 2) chk("pkt lck held", 128'(lck_o[0]), 128'(1'b1));
        end
        chk("pkt ack count", 128'(acks), 128'(3));
        chk("pkt lck drop", 128'(lck_o), 128'(2'b00));
        chk("pkt no err", 128'(err_o), 128'(1'b0));
        idle(1);
        chk("pkt ack ends", 128'(ack_o), 128'(2'b00));

        // Fill and overflow on VC1
        do_reset();
        step(1'b1, 1, mk(HEAD, 32'h200), 2'b00);
        for (int k = 1; k <= 3; k++) step(1'b1, 1, mk(BODY, 32'h200 + k), 2'b00);
        chk("fill no err yet", 128'(err_o), 128'(1'b0));
        step(1'b1, 1, mk(TAIL, 32'h204), 2'b00);
        chk("overflow err", 128'(err_o), 128'(1'b1));
        chk("overflow head kept", 128'(out_data[67:34]), 128'(mk(HEAD, 32'h200)));
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 0, '0, 2'b10);
            acks += int'(ack_o[1]);
        end
        idle(2);
        acks += int'(ack_o[1]);
        chk("overflow ack count", 128'(acks), 128'(4));
        chk("overflow drained", 128'(out_valid), 128'(2'b00));

        // Full FIFO with push and pop in the same cycle; wraps over 10 packets
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 0, mk(HT, 32'h300 + k), 2'b00);
        step(1'b1, 0, mk(HT, 32'h304), 2'b01);
        chk("full pushpop err", 128'(err_o), 128'(1'b0));
        chk("full pushpop head", 128'(out_data[33:0]), 128'(mk(HT, 32'h301)));
        for (int k = 5; k <= 9; k++) step(1'b1, 0, mk(HT, 32'h300 + k), 2'b01);
        for (int k = 0; k < 3; k++) step(1'b0, 0, '0, 2'b01);
        chk("wrap last flit", 128'(out_data[33:0]), 128'(mk(HT, 32'h309)));
        step(1'b0, 0, '0, 2'b01);
        chk("wrap empty", 128'({out_valid, lck_o, err_o}), 128'(5'b0));

        // Interleaved VCs, popping VC1 only
        do_reset();
        step(1'b1, 0, mk(HT, 32'h400), 2'b00);
        step(1'b1, 1, mk(HT, 32'h410), 2'b00);
        step(1'b1, 0, mk(HT, 32'h401), 2'b00);
        step(1'b1, 1, mk(HT, 32'h411), 2'b00);
        chk("ilv lck both", 128'(lck_o), 128'(2'b11));
        step(1'b0, 0, '0, 2'b10);
        chk("ilv ack vc1", 128'(ack_o), 128'(2'b10));
        chk("ilv lck still", 128'(lck_o), 128'(2'b11));
        step(1'b0, 0, '0, 2'b10);
        chk("ilv lck vc1 drop", 128'(lck_o), 128'(2'b01));
        chk("ilv vc0 intact", 128'(out_data[33:0]), 128'(mk(HT, 32'h400)));

        // Protocol error, then reset while VC1 holds a partial packet
        do_reset();
        step(1'b1, 0, mk(BODY, 32'h500), 2'b00);
        chk("proto err", 128'(err_o), 128'(1'b1));
        step(1'b1, 1, mk(HEAD, 32'h510), 2'b00);
        step(1'b1, 1, mk(BODY, 32'h511), 2'b00);
        chk("pre-reset valid", 128'(out_valid), 128'(2'b11));
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", 128'({out_valid, ack_o, lck_o, err_o, out_data}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 0, '0, 2'b11);
            acks += int'(ack_o[0]) + int'(ack_o[1]);
        end
        chk("post-reset no acks", 128'(acks), 128'(0));
        chk("post-reset empty", 128'({out_valid, lck_o, err_o}), 128'(5'b0));

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
